dmem_rmw_ctrl: RTL and testbench

DMEM_RMW_CTRL -- requirements
Module: dmem_rmw_ctrl

---
 rtl/riscv_defs.sv | 29 ++
 rtl/dmem_byte_merge.sv | 27 ++
 rtl/dmem_rmw_ctrl.sv | 151 +++++++++++++++
 tb/tb_dmem_rmw_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared RISC-V load/store encodings and data-memory controller types.
package riscv_defs;

  localparam int NB_FUNCT3   = 3;
  localparam int NB_BYTE_OFS = 2;

  localparam logic [NB_FUNCT3-1:0] F3_LB  = 3'b000;
  localparam logic [NB_FUNCT3-1:0] F3_LH  = 3'b001;
  localparam logic [NB_FUNCT3-1:0] F3_LW  = 3'b010;
  localparam logic [NB_FUNCT3-1:0] F3_LBU = 3'b100;
  localparam logic [NB_FUNCT3-1:0] F3_LHU = 3'b101;
  localparam logic [NB_FUNCT3-1:0] F3_SB  = 3'b000;
  localparam logic [NB_FUNCT3-1:0] F3_SH  = 3'b001;
  localparam logic [NB_FUNCT3-1:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RMW_READ, RMW_WRITE, RESP
  } dmem_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} dmem_size_t;

  // Access size; any code that is not a known byte/halfword op acts as a word op.
  function automatic dmem_size_t dmem_size(input logic wr, input logic [NB_FUNCT3-1:0] f3);
    if (f3 == F3_LB || (!wr && f3 == F3_LBU))      return SZ_B;
    else if (f3 == F3_LH || (!wr && f3 == F3_LHU)) return SZ_H;
    else                                           return SZ_W;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Replaces the byte/halfword lanes of an old SRAM word with store data at a byte offset.
module dmem_byte_merge
  import riscv_defs::*;
#(
  parameter int NB_WORD = 32
) (
  input  logic [NB_WORD-1:0]     i_old,
  input  logic [NB_WORD-1:0]     i_data,
  input  logic [NB_BYTE_OFS-1:0] i_ofs,
  input  logic [1:0]             i_size,
  output logic [NB_WORD-1:0]     o_word
);

  logic [NB_WORD-1:0] lane_mask, mask_sh, data_sh;

  always_comb begin
    case (i_size)
      SZ_B:    lane_mask = NB_WORD'(8'hFF);
      SZ_H:    lane_mask = NB_WORD'(16'hFFFF);
      default: lane_mask = '1;
    endcase
    mask_sh = lane_mask << {i_ofs, 3'b000};
    data_sh = i_data << {i_ofs, 3'b000};
    o_word  = (i_old & ~mask_sh) | (data_sh & mask_sh);
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller: aligned loads/stores to a 1-cycle SRAM, sub-word stores via read-modify-write.
module dmem_rmw_ctrl
  import riscv_defs::*;
#(
  parameter int NB_WORD      = 32,
  parameter int NB_ADDR      = 32,
  parameter int DEPTH_WORDS  = 1024,
  localparam int NB_SRAM_ADDR = $clog2(DEPTH_WORDS)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wr,
  input  logic [NB_ADDR-1:0]      i_req_addr,
  input  logic [NB_WORD-1:0]      i_req_wdata,
  input  logic [NB_FUNCT3-1:0]    i_req_funct3,
  output logic                    o_rsp_valid,
  output logic [NB_WORD-1:0]      o_rsp_rdata,
  output logic                    o_misaligned,
  output logic                    o_fault,
  output logic                    o_sram_en,
  output logic                    o_sram_we,
  output logic [NB_SRAM_ADDR-1:0] o_sram_addr,
  output logic [NB_WORD-1:0]      o_sram_wdata,
  input  logic [NB_WORD-1:0]      i_sram_rdata
);

  localparam int NB_LOC = NB_SRAM_ADDR + NB_BYTE_OFS;

  dmem_state_t            state_q, state_d;
  logic [NB_LOC-1:0]      addr_q;
  logic [NB_WORD-1:0]     wdata_q;
  logic [NB_FUNCT3-1:0]   funct3_q;
  logic                   wr_q, mis_q, flt_q;

  logic                   req_go, req_flt, req_mis;
  dmem_size_t             req_size, cur_size;
  logic [NB_ADDR-1:0]     addr_hi;
  logic [NB_WORD-1:0]     rd_sh, ld_data, merged;

  // Outputs are forced idle while reset is high, so an in-flight RMW write is dropped.
  assign req_go   = i_req_valid && (state_q == IDLE) && !i_reset;
  assign req_size = dmem_size(i_req_wr, i_req_funct3);
  assign addr_hi  = i_req_addr >> NB_LOC;
  assign req_flt  = |addr_hi;
  assign req_mis  = ((req_size == SZ_H) && i_req_addr[0]) ||
                    ((req_size == SZ_W) && (i_req_addr[1:0] != 2'b00));
  assign cur_size = dmem_size(wr_q, funct3_q);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      wr_q     <= 1'b0;
      mis_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_go) begin
        addr_q   <= i_req_addr[NB_LOC-1:0];
        wdata_q  <= i_req_wdata;
        funct3_q <= i_req_funct3;
        wr_q     <= i_req_wr;
        mis_q    <= req_mis && !req_flt;
        flt_q    <= req_flt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_go) begin
        if (req_flt || req_mis)   state_d = RESP;
        else if (!i_req_wr)       state_d = RD_WAIT;
        else if (req_size == SZ_W) state_d = RESP;
        else                      state_d = RMW_WRITE;
      end
      RD_WAIT:   state_d = IDLE;
      RMW_READ:  state_d = RMW_WRITE;
      RMW_WRITE: state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign rd_sh = i_sram_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (cur_size)
      SZ_B:    ld_data = rd_sh & NB_WORD'(8'hFF);
      SZ_H:    ld_data = rd_sh & NB_WORD'(16'hFFFF);
      default: ld_data = rd_sh;
    endcase
  end

  dmem_byte_merge #(.NB_WORD(NB_WORD)) u_merge (
    .i_old  (i_sram_rdata),
    .i_data (wdata_q),
    .i_ofs  (addr_q[1:0]),
    .i_size (cur_size),
    .o_word (merged)
  );

  always_comb begin
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_rsp_rdata  = '0;
    o_misaligned = 1'b0;
    o_fault      = 1'b0;
    o_sram_en    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (!i_reset) begin
      case (state_q)
        IDLE: begin
          o_req_ready = 1'b1;
          if (req_go && !req_flt && !req_mis) begin
            o_sram_en   = 1'b1;
            o_sram_addr = i_req_addr[NB_LOC-1:NB_BYTE_OFS];
            if (i_req_wr && req_size == SZ_W) begin
              o_sram_we    = 1'b1;
              o_sram_wdata = i_req_wdata;
            end
          end
        end
        RD_WAIT: begin
          o_rsp_valid = 1'b1;
          o_rsp_rdata = ld_data;
        end
        RMW_WRITE: begin
          o_sram_en    = 1'b1;
          o_sram_we    = 1'b1;
          o_sram_addr  = addr_q[NB_LOC-1:NB_BYTE_OFS];
          o_sram_wdata = merged;
        end
        RESP: begin
          o_rsp_valid  = 1'b1;
          o_misaligned = mis_q;
          o_fault      = flt_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed + seeded-random bench for dmem_rmw_ctrl against a behavioral SRAM and byte-array model.
module tb_dmem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_f3;
  logic        rsp_valid, mis, flt;
  logic [31:0] rsp_rdata;
  logic        sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem [0:1023];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_rmw_ctrl dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_funct3(req_f3),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_misaligned(mis), .o_fault(flt),
    .o_sram_en(sram_en), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    else if (sram_en) sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic pl(input int w, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = 10'(w); pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request; k counts cycles after acceptance (acceptance cycle is k=0).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, output int lat, output logic [31:0] rd,
                        output logic m, output logic f, output int n_en, output int we_k,
                        output logic [31:0] we_d);
    lat = -1; rd = '0; m = 1'b0; f = 1'b0; n_en = 0; we_k = -1; we_d = '0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_f3 = f3;
    #1;
    for (int t = 0; t < 10 && !req_ready; t++) begin
      @(negedge clk); #1;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    if (sram_en) n_en++;
    if (sram_en && sram_we) begin we_k = 0; we_d = sram_wdata; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sram_en) n_en++;
      if (sram_en && sram_we) begin we_k = k; we_d = sram_wdata; end
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; m = mis; f = flt;
        break;
      end
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0]  ref_b [0:63];
  int          lat, n_en, we_k, n_acc, n_rsp;
  logic [31:0] rd, we_d, e, a, w;
  logic        m, f, wr;
  logic [2:0]  f3;
  int          nb;
  logic [2:0]  ld_f3 [0:4];

  initial begin
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'h1; req_f3 = 3'b010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_outs", {26'd0, rsp_valid, mis, flt, sram_en, sram_we, 1'b0}, 0);
    chk("rst_data", rsp_rdata | sram_wdata | 32'(sram_addr), 0);
    req_valid = 1'b0;
    pl(3, 32'hAABBCCDD);
    pl(8, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(req_ready), 1);

    // Loads of each size from a preloaded word
    do_req(0, 32'h0E, 0, 3'b000, lat, rd, m, f, n_en, we_k, we_d);
    chk("lb_lat", 32'(lat), 1); chk("lb_data", rd, 32'h000000BB); chk("lb_en", 32'(n_en), 1);
    chk("lb_nowe", 32'(we_k), 32'hFFFFFFFF);
    do_req(0, 32'h0F, 0, 3'b100, lat, rd, m, f, n_en, we_k, we_d);
    chk("lbu_data", rd, 32'h000000AA);
    do_req(0, 32'h0E, 0, 3'b001, lat, rd, m, f, n_en, we_k, we_d);
    chk("lh_data", rd, 32'h0000AABB);
    do_req(0, 32'h0C, 0, 3'b101, lat, rd, m, f, n_en, we_k, we_d);
    chk("lhu_data", rd, 32'h0000CCDD);
    do_req(0, 32'h0C, 0, 3'b010, lat, rd, m, f, n_en, we_k, we_d);
    chk("lw_data", rd, 32'hAABBCCDD); chk("lw_mis", {31'd0, m}, 0);

    // Byte store via read-modify-write
    do_req(1, 32'h0D, 32'h11, 3'b000, lat, rd, m, f, n_en, we_k, we_d);
    chk("sb_lat", 32'(lat), 2); chk("sb_we_k", 32'(we_k), 1);
    chk("sb_we_d", we_d, 32'hAABB11DD); chk("sb_rd", rd, 0); chk("sb_en", 32'(n_en), 2);
    do_req(0, 32'h0C, 0, 3'b010, lat, rd, m, f, n_en, we_k, we_d);
    chk("sb_lw", rd, 32'hAABB11DD);

    // Misaligned and fault
    do_req(1, 32'h0F, 32'h1234, 3'b001, lat, rd, m, f, n_en, we_k, we_d);
    chk("sh_mis_lat", 32'(lat), 1); chk("sh_mis", {31'd0, m}, 1);
    chk("sh_mis_en", 32'(n_en), 0); chk("sh_mis_rd", rd, 0);
    do_req(0, 32'h1000, 0, 3'b010, lat, rd, m, f, n_en, we_k, we_d);
    chk("lw_flt", {30'd0, f, m}, 32'd2); chk("lw_flt_en", 32'(n_en), 0); chk("lw_flt_lat", 32'(lat), 1);
    do_req(0, 32'h1001, 0, 3'b010, lat, rd, m, f, n_en, we_k, we_d);
    chk("flt_prio", {30'd0, f, m}, 32'd2);

    // Word store, then halfword merge, then unknown funct3
    do_req(1, 32'h20, 32'hDEADBEEF, 3'b010, lat, rd, m, f, n_en, we_k, we_d);
    chk("sw_lat", 32'(lat), 1); chk("sw_we_k", 32'(we_k), 0); chk("sw_rd", rd, 0);
    do_req(1, 32'h22, 32'hFFFF5A5A, 3'b001, lat, rd, m, f, n_en, we_k, we_d);
    chk("sh_we_d", we_d, 32'h5A5ABEEF);
    do_req(0, 32'h20, 0, 3'b011, lat, rd, m, f, n_en, we_k, we_d);
    chk("unk_lw", rd, 32'h5A5ABEEF);
    do_req(0, 32'h22, 0, 3'b110, lat, rd, m, f, n_en, we_k, we_d);
    chk("unk_mis", {31'd0, m}, 1);
    do_req(1, 32'h24, 32'h0BADF00D, 3'b101, lat, rd, m, f, n_en, we_k, we_d);
    chk("unk_sw_k", 32'(we_k), 0); chk("unk_sw_d", we_d, 32'h0BADF00D);

    // Reset during the cycle after a sub-word store is accepted
    pl(5, 32'h12345678);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h14; req_wdata = 32'h99; req_f3 = 3'b000;
    #1; chk("ra_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("ra_no_en", 32'(sram_en), 0); chk("ra_no_rsp", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ra_rdy", 32'(req_ready), 1); chk("ra_no_rsp2", 32'(rsp_valid | sram_en), 0);
    do_req(0, 32'h14, 0, 3'b010, lat, rd, m, f, n_en, we_k, we_d);
    chk("ra_mem", rd, 32'h12345678);

    // Random mixed stream over words 0..15
    for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) pl(i, {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
    n_acc = 0; n_rsp = 0;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      a  = 32'($urandom_range(0, 63)) & ~(32'(nb) - 1);
      w  = $urandom;
      do_req(wr, a, w, f3, lat, rd, m, f, n_en, we_k, we_d);
      n_acc++;
      if (lat > 0) n_rsp++;
      if (wr) begin
        for (int b = 0; b < nb; b++) ref_b[a+b] = w[8*b +: 8];
      end else begin
        e = '0;
        for (int b = 0; b < nb; b++) e[8*b +: 8] = ref_b[a+b];
        chk($sformatf("rnd_ld%0d", i), rd, e);
      end
    end
    chk("rnd_rsp_cnt", 32'(n_rsp), 32'(n_acc));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
